// File: rtl/change_dispenser.sv
// change_dispenser -- pays out a refund amount as a sequence of single coins,
// largest eligible denomination first, one hopper handshake per coin.
//
// Build option: define CHANGE_HOPPER_EN to add the hopper_empty port and skip
// denominations whose hopper reports empty. Left undefined, every hopper is
// treated as stocked and the port does not exist.
//
// Ports
//   clk          in   single clock, rising edge
//   reset        in   asynchronous, active-high
//   start        in   one-cycle payout request, honoured only when idle
//   amount[7:0]  in   refund value, captured on an accepted start
//   eject_ack    in   hopper confirms one coin ejected (used only in EJECT)
//   hopper_empty[4:0] in  empty flags {100,50,20,10,5} (CHANGE_HOPPER_EN only)
//   busy         out  high whenever not idle
//   eject_req    out  request one coin of eject_sel
//   eject_sel[4:0] out one-hot coin: 00001=5 00010=10 00100=20 01000=50 10000=100
//   done         out  one-cycle completion pulse
//   remainder[7:0] out unpaid value, valid from done until next accepted start
//   timeout_err  out  an ack wait expired during the last payout
//   coins_paid[5:0] out coins ejected in the current/last payout (saturating)
//
// state  | meaning
// IDLE   | waiting for start
// SELECT | pick largest eligible coin <= remaining, or finish
// EJECT  | eject_req held, waiting for eject_ack or timeout
// DONE   | done pulse, remainder published

module change_dispenser #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] amount,
    input  logic       eject_ack,
`ifdef CHANGE_HOPPER_EN
    input  logic [4:0] hopper_empty,
`endif
    output logic       busy,
    output logic       eject_req,
    output logic [4:0] eject_sel,
    output logic       done,
    output logic [7:0] remainder,
    output logic       timeout_err,
    output logic [5:0] coins_paid
);

    typedef enum logic [1:0] {IDLE, SELECT, EJECT, DONE} state_t;

    // The wait counter starts at 0 on entry to EJECT, so the last permitted
    // cycle is ACK_TIMEOUT-1; eject_req is then high ACK_TIMEOUT cycles.
    localparam logic [7:0] LAST_WAIT = 8'(ACK_TIMEOUT - 1);

    state_t     state;
    logic [7:0] remaining;
    logic [7:0] wait_cnt;
    logic [4:0] eligible;
    logic [4:0] pick_sel;
    logic [7:0] sel_val;

    always_comb begin
`ifdef CHANGE_HOPPER_EN
        eligible = ~hopper_empty;
`else
        eligible = 5'b11111;
`endif
    end

    always_comb begin
        pick_sel = 5'b00000;
        if (eligible[4] && remaining >= 8'd100)     pick_sel = 5'b10000;
        else if (eligible[3] && remaining >= 8'd50) pick_sel = 5'b01000;
        else if (eligible[2] && remaining >= 8'd20) pick_sel = 5'b00100;
        else if (eligible[1] && remaining >= 8'd10) pick_sel = 5'b00010;
        else if (eligible[0] && remaining >= 8'd5)  pick_sel = 5'b00001;
    end

    always_comb begin
        sel_val = 8'd0;
        case (eject_sel)
            5'b10000: sel_val = 8'd100;
            5'b01000: sel_val = 8'd50;
            5'b00100: sel_val = 8'd20;
            5'b00010: sel_val = 8'd10;
            5'b00001: sel_val = 8'd5;
            default:  sel_val = 8'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            remaining   <= 8'd0;
            wait_cnt    <= 8'd0;
            busy        <= 1'b0;
            eject_req   <= 1'b0;
            eject_sel   <= 5'b00000;
            done        <= 1'b0;
            remainder   <= 8'd0;
            timeout_err <= 1'b0;
            coins_paid  <= 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        remaining   <= amount;
                        coins_paid  <= 6'd0;
                        timeout_err <= 1'b0;
                        wait_cnt    <= 8'd0;
                        busy        <= 1'b1;
                        state       <= SELECT;
                    end
                end
                SELECT: begin
                    if (pick_sel != 5'b00000) begin
                        eject_sel <= pick_sel;
                        eject_req <= 1'b1;
                        wait_cnt  <= 8'd0;
                        state     <= EJECT;
                    end else begin
                        eject_sel <= 5'b00000;
                        done      <= 1'b1;
                        remainder <= remaining;
                        state     <= DONE;
                    end
                end
                EJECT: begin
                    // ack is checked first so a coincident timeout loses
                    if (eject_ack) begin
                        remaining  <= remaining - sel_val;
                        coins_paid <= (coins_paid == 6'd63) ? 6'd63 : coins_paid + 6'd1;
                        wait_cnt   <= 8'd0;
                        eject_req  <= 1'b0;
                        state      <= SELECT;
                    end else if (wait_cnt == LAST_WAIT) begin
                        timeout_err <= 1'b1;
                        eject_req   <= 1'b0;
                        wait_cnt    <= 8'd0;
                        done        <= 1'b1;
                        remainder   <= remaining;
                        state       <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

    localparam logic [4:0] C100 = 5'b10000;
    localparam logic [4:0] C50  = 5'b01000;
    localparam logic [4:0] C20  = 5'b00100;
    localparam logic [4:0] C10  = 5'b00010;
    localparam logic [4:0] C5   = 5'b00001;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] amount = 8'd0;
    logic       eject_ack = 1'b0;
    logic [4:0] hopper_empty = 5'b00000;
    logic       busy, eject_req, done, timeout_err;
    logic [4:0] eject_sel;
    logic [7:0] remainder;
    logic [5:0] coins_paid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    change_dispenser #(.ACK_TIMEOUT(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .amount      (amount),
        .eject_ack   (eject_ack),
`ifdef CHANGE_HOPPER_EN
        .hopper_empty(hopper_empty),
`endif
        .busy        (busy),
        .eject_req   (eject_req),
        .eject_sel   (eject_sel),
        .done        (done),
        .remainder   (remainder),
        .timeout_err (timeout_err),
        .coins_paid  (coins_paid)
    );

    typedef struct {
        logic [7:0]  amount;
        int          ack_delay;   // cycles of eject_req before ack; 0 = never ack
        bit          inject;      // issue a second start during the first eject
        int          nseq;
        logic [39:0] seq;         // coin i in seq[i*5 +: 5]
        logic [7:0]  rem;
        logic [5:0]  coins;
        logic        terr;
        int          req_cycles;  // -1 = not checked
        int          latency;     // cycle of done after the start edge, -1 = not checked
    } vec_t;

    vec_t vecs[9];

    function automatic logic [39:0] mk_seq(input logic [4:0] a, b, c, d, e);
        logic [39:0] s;
        s = '0;
        s[4:0] = a; s[9:5] = b; s[14:10] = c; s[19:15] = d; s[24:20] = e;
        return s;
    endfunction

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_payout(input logic [7:0] amt, input int ack_delay, input bit inject,
                              output logic [39:0] seq, output int nseq, output int req_cycles,
                              output int done_cnt, output int latency, output logic [7:0] rem,
                              output logic [5:0] coins, output logic terr, output bit finished);
        int  rc;
        bit  prev_req;
        bit  injected;
        seq = '0; nseq = 0; req_cycles = 0; done_cnt = 0; latency = -1;
        rem = 'x; coins = 'x; terr = 'x; finished = 0;
        rc = 0; prev_req = 0; injected = 0;
        @(negedge clk);
        amount = amt;
        start  = 1'b1;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (eject_ack) begin
                eject_ack = 1'b0;
                rc = 0;
            end
            if (!busy) begin
                finished = 1;
                break;
            end
            if (done) begin
                done_cnt++;
                if (latency < 0) latency = cyc;
                rem = remainder; coins = coins_paid; terr = timeout_err;
            end
            if (eject_req) begin
                if (!prev_req && nseq < 8) begin
                    seq[nseq*5 +: 5] = eject_sel;
                    nseq++;
                end
                req_cycles++;
                rc++;
                if (inject && !injected) begin
                    start = 1'b1; amount = 8'd200; injected = 1;
                end
                if (rc == ack_delay) eject_ack = 1'b1;
            end
            prev_req = eject_req;
        end
    endtask

    initial begin
        logic [39:0] seq;
        int nseq, req_cycles, done_cnt, latency;
        logic [7:0] rem;
        logic [5:0] coins;
        logic terr;
        bit finished;

        vecs[0] = '{8'd185, 1, 0, 5, mk_seq(C100, C50, C20, C10, C5), 8'd0, 6'd5, 1'b0, 5, 12};
        vecs[1] = '{8'd3,   1, 0, 0, '0,                              8'd3, 6'd0, 1'b0, 0, 2};
        vecs[2] = '{8'd20,  0, 0, 1, mk_seq(C20, 0, 0, 0, 0),          8'd20, 6'd0, 1'b1, 8, 10};
        vecs[3] = '{8'd60,  1, 1, 2, mk_seq(C50, C10, 0, 0, 0),        8'd0, 6'd2, 1'b0, 2, 6};
        vecs[4] = '{8'd255, 2, 0, 4, mk_seq(C100, C100, C50, C5, 0),   8'd0, 6'd4, 1'b0, 8, -1};
        vecs[5] = '{8'd20,  8, 0, 1, mk_seq(C20, 0, 0, 0, 0),          8'd0, 6'd1, 1'b0, 8, 11};
        vecs[6] = '{8'd4,   1, 0, 0, '0,                              8'd4, 6'd0, 1'b0, 0, 2};
        vecs[7] = '{8'd7,   3, 0, 1, mk_seq(C5, 0, 0, 0, 0),           8'd2, 6'd1, 1'b0, 3, 6};
        vecs[8] = '{8'd100, 1, 0, 1, mk_seq(C100, 0, 0, 0, 0),         8'd0, 6'd1, 1'b0, 1, 4};

        // reset state
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_eject_req", eject_req, 0);
        chk("rst_eject_sel", eject_sel, 0);
        chk("rst_done", done, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_coins_paid", coins_paid, 0);
        reset = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 9; v++) begin
            run_payout(vecs[v].amount, vecs[v].ack_delay, vecs[v].inject,
                       seq, nseq, req_cycles, done_cnt, latency, rem, coins, terr, finished);
            chk($sformatf("v%0d_finished", v), finished, 1);
            chk($sformatf("v%0d_done_pulses", v), done_cnt, 1);
            chk($sformatf("v%0d_ncoins_req", v), nseq, vecs[v].nseq);
            for (int i = 0; i < vecs[v].nseq; i++)
                chk($sformatf("v%0d_sel%0d", v, i), seq[i*5 +: 5], vecs[v].seq[i*5 +: 5]);
            chk($sformatf("v%0d_remainder", v), rem, vecs[v].rem);
            chk($sformatf("v%0d_coins_paid", v), coins, vecs[v].coins);
            chk($sformatf("v%0d_timeout_err", v), terr, vecs[v].terr);
            if (vecs[v].req_cycles >= 0)
                chk($sformatf("v%0d_req_cycles", v), req_cycles, vecs[v].req_cycles);
            if (vecs[v].latency >= 0)
                chk($sformatf("v%0d_latency", v), latency, vecs[v].latency);
            chk($sformatf("v%0d_remainder_held", v), remainder, vecs[v].rem);
        end

        // ack while idle must not touch anything
        eject_ack = 1'b1;
        repeat (3) @(negedge clk);
        eject_ack = 1'b0;
        chk("idle_ack_busy", busy, 0);
        chk("idle_ack_coins", coins_paid, 1);
        chk("idle_ack_req", eject_req, 0);

`ifdef CHANGE_HOPPER_EN
        hopper_empty = 5'b10000;
        run_payout(8'd100, 1, 0, seq, nseq, req_cycles, done_cnt, latency, rem, coins, terr, finished);
        hopper_empty = 5'b00000;
        chk("hop_finished", finished, 1);
        chk("hop_ncoins", nseq, 2);
        chk("hop_sel0", seq[4:0], C50);
        chk("hop_sel1", seq[9:5], C50);
        chk("hop_remainder", rem, 0);
        chk("hop_coins", coins, 2);
`endif

        // reset during the first eject
        begin
            bit seen_req;
            bit seen_done;
            seen_req = 0;
            seen_done = 0;
            @(negedge clk);
            amount = 8'd100;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < 10 && !seen_req; i++) begin
                @(negedge clk);
                if (eject_req) seen_req = 1;
            end
            chk("mid_reset_req_seen", seen_req, 1);
            #2 reset = 1'b1;
            #1;
            chk("mid_reset_busy", busy, 0);
            chk("mid_reset_req", eject_req, 0);
            chk("mid_reset_sel", eject_sel, 0);
            chk("mid_reset_coins", coins_paid, 0);
            chk("mid_reset_remainder", remainder, 0);
            chk("mid_reset_terr", timeout_err, 0);
            @(negedge clk);
            reset = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (done || busy) seen_done = 1;
            end
            chk("mid_reset_no_done", seen_done, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
